probe_uplink_arbiter: RTL and testbench
=======================================

Name: probe_uplink_arbiter

Overview:
Shares one 32-bit serial-probe uplink between NumProbes capture probes that dump packets on UCLK. Each probe presents a packet: one header word {ProbeId[15:0], wordCount[15:0]}, then wordCount data words. After the last data word the probe needs one extra ACK cycle to leave its dumping state. The arbiter grants whole packets round-robin, forwards the words to the uplink, and issues that final release ACK itself.

Parameters:
NumProbes, 4, number of requesting probes (2..16)
IdxWidth, 2, width of OWNER index; must satisfy 2**IdxWidth >= NumProbes
TimeoutCycles, 255, stall limit used only when PROBE_ARB_TIMEOUT_EN is defined (1..65535)

Ports:
UCLK  in  1  uplink clock; all state on posedge
URST  in  1  asynchronous, active-low reset
REQVALID  in  NumProbes  per-probe data valid (probe DATAVALID)
REQDATA  in  32*NumProbes  per-probe data word; probe i occupies bits [32i+31:32i]
REQACK  out  NumProbes  per-probe word accept (probe ACK)
OUTVALID  out  1  uplink word valid
OUTDATA  out  32  uplink word
OUTACK  in  1  uplink accepts word; a transfer is OUTVALID && OUTACK
BUSY  out  1  high whenever state != IDLE
OWNER  out  IdxWidth  index of the granted probe
ERR  out  1  one-cycle abort pulse (feature only)

Behaviour:
- Reset (URST low, asynchronous):
  - state = IDLE; OWNER = 0; lastGrant = NumProbes-1 (so probe 0 wins first); count = 0.
  - Outputs: OUTVALID = 0, REQACK = 0, BUSY = 0, ERR = 0, OUTDATA = 0.
  - Reset asserted mid-packet abandons the packet immediately; no release ACK is issued.
- States: IDLE, HEADER, STREAM, RELEASE.
- IDLE:
  - Search REQVALID round-robin starting at lastGrant+1, wrapping at NumProbes.
  - On the first hit, register OWNER and go to HEADER the next cycle.
  - No REQVALID bit set: stay in IDLE.
  - Grant latency from REQVALID rising is 1 cycle. No output is valid in IDLE.
- HEADER / STREAM datapath (combinational from the owner):
  - OUTVALID = REQVALID[OWNER]; OUTDATA = REQDATA[OWNER].
  - REQACK[OWNER] = OUTACK && REQVALID[OWNER]; all other REQACK bits are 0.
  - OUTDATA = 0 whenever OUTVALID = 0.
- HEADER:
  - On transfer, count <= OUTDATA[15:0].
  - If OUTDATA[15:0] == 0, go to RELEASE; otherwise go to STREAM.
- STREAM:
  - On each transfer, count <= count-1 (16-bit).
  - A transfer with count == 1 goes to RELEASE.
  - No transfer: hold state and count.
- RELEASE (exactly 1 cycle):
  - REQACK[OWNER] = 1; OUTVALID = 0; the probe's stale word is not forwarded.
  - Then lastGrant <= OWNER and state <= IDLE.
- Other rules:
  - A packet is never preempted; requests from other probes wait.
  - Owner dropping REQVALID mid-packet is legal; state and count hold until it returns.
  - RELEASE→IDLE→HEADER takes at least 2 cycles between packets.
  - OUTACK is ignored in IDLE and RELEASE.
  - OWNER holds its last value in IDLE.

Optional Feature:
PROBE_ARB_TIMEOUT_EN
- Defined:
  - A 16-bit stall counter counts consecutive HEADER/STREAM cycles with no transfer; it clears on any transfer and on entry to HEADER.
  - Reaching TimeoutCycles: pulse ERR for 1 cycle, go to IDLE directly with lastGrant <= OWNER and no RELEASE ACK.
  - The stall counter resets to 0.
- Undefined: no stall counter; ERR tied 0; a stalled packet holds the uplink indefinitely.

Test Plan:
- Single packet: probe 1 with header 0x0001_0003 and data A,B,C; OUTACK=1 → OUTDATA sequence 0x00010003,A,B,C on 4 consecutive cycles; then 1 RELEASE cycle with REQACK=0b0010 and OUTVALID=0; BUSY low the next cycle.
- Round-robin: REQVALID=0b1111 held, each packet with wordCount=1 → owners granted in order 0,1,2,3,0; no packet interleaving.
- Zero-length: header 0x0002_0000 from probe 2 → header forwarded, next cycle RELEASE ACK, then IDLE; exactly 2 REQACK pulses to probe 2.
- Backpressure: OUTACK toggled 1,0,0,1,… during a wordCount=2 packet → no REQACK while OUTACK=0; each word appears exactly once on a transfer; count unchanged across stalls.
- Async reset: assert URST low mid-STREAM (count=5) → same-instant OUTVALID=0, REQACK=0, BUSY=0; after release, first grant goes to probe 0.
- Timeout (PROBE_ARB_TIMEOUT_EN, TimeoutCycles=8): owner drops REQVALID after header → ERR pulses on cycle 8 of the stall, BUSY=0 next cycle, next requester granted; with the macro undefined, ERR stays 0 and BUSY stays 1.

Source files
------------

// File: rtl/probe_uplink_arbiter.sv
// Round-robin arbiter that shares one 32-bit uplink between capture probes, one whole packet per grant.
// Optional stall watchdog enabled by defining PROBE_ARB_TIMEOUT_EN.
module probe_uplink_arbiter #(
  parameter int NumProbes     = 4,
  parameter int IdxWidth      = 2,
  parameter int TimeoutCycles = 255
) (
  input  logic                   UCLK,
  input  logic                   URST,
  input  logic [NumProbes-1:0]   REQVALID,
  input  logic [32*NumProbes-1:0] REQDATA,
  output logic [NumProbes-1:0]   REQACK,
  output logic                   OUTVALID,
  output logic [31:0]            OUTDATA,
  input  logic                   OUTACK,
  output logic                   BUSY,
  output logic [IdxWidth-1:0]    OWNER,
  output logic                   ERR
);

  localparam int PadWidth = 1 << IdxWidth;
  localparam int CandW    = IdxWidth + 1;
  localparam logic [CandW-1:0] NumP = CandW'(NumProbes);

  if (PadWidth < NumProbes || NumProbes < 2 || TimeoutCycles < 1 || TimeoutCycles > 65535) begin : g_paramCheck
    $error("probe_uplink_arbiter: illegal parameter combination");
  end

  typedef enum logic [1:0] {IDLE, HEADER, STREAM, RELEASE} state_t;

  state_t              r_state, w_stateNext;
  logic [IdxWidth-1:0] r_owner, w_ownerNext;
  logic [IdxWidth-1:0] r_lastGrant, w_lastGrantNext;
  logic [IdxWidth-1:0] w_pick;
  logic [15:0]         r_count, w_countNext;
  logic [CandW-1:0]    w_cand;
  logic                w_found;
  logic                w_xfer;
  logic                w_ownerValid;
  logic [PadWidth-1:0] w_reqPad;
  logic [PadWidth-1:0] w_ackPad;
  logic [31:0]         w_words [PadWidth];

`ifdef PROBE_ARB_TIMEOUT_EN
  localparam logic [15:0] StallLimit = 16'(TimeoutCycles - 1);
  logic [15:0] r_stall, w_stallNext;
`endif

  // Pad the request vector and data words to a power of two so OWNER can index them directly.
  assign w_reqPad = PadWidth'(REQVALID);

  for (genvar g = 0; g < PadWidth; g++) begin : g_words
    if (g < NumProbes) begin : g_real
      assign w_words[g] = REQDATA[32*g +: 32];
    end else begin : g_pad
      assign w_words[g] = '0;
    end
  end

  assign REQACK = w_ackPad[NumProbes-1:0];
  assign OWNER  = r_owner;

  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_cand  = '0;
    for (int k = 1; k <= NumProbes; k++) begin
      w_cand = {1'b0, r_lastGrant} + CandW'(k);
      if (w_cand >= NumP) w_cand = w_cand - NumP;
      if (!w_found && w_reqPad[w_cand[IdxWidth-1:0]]) begin
        w_found = 1'b1;
        w_pick  = w_cand[IdxWidth-1:0];
      end
    end
  end

  always_comb begin
    w_stateNext     = r_state;
    w_ownerNext     = r_owner;
    w_lastGrantNext = r_lastGrant;
    w_countNext     = r_count;
    w_ownerValid    = w_reqPad[r_owner];
    w_xfer          = 1'b0;
    w_ackPad        = '0;
    OUTVALID        = 1'b0;
    OUTDATA         = '0;
    BUSY            = (r_state != IDLE);
    ERR             = 1'b0;
`ifdef PROBE_ARB_TIMEOUT_EN
    w_stallNext     = r_stall;
`endif
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_ownerNext = w_pick;
          w_stateNext = HEADER;
`ifdef PROBE_ARB_TIMEOUT_EN
          w_stallNext = '0;
`endif
        end
      end
      HEADER, STREAM: begin
        OUTVALID = w_ownerValid;
        OUTDATA  = w_ownerValid ? w_words[r_owner] : '0;
        w_xfer   = w_ownerValid && OUTACK;
        w_ackPad[r_owner] = w_xfer;
        if (w_xfer) begin
          if (r_state == HEADER) begin
            w_countNext = w_words[r_owner][15:0];
            w_stateNext = (w_words[r_owner][15:0] == 16'd0) ? RELEASE : STREAM;
          end else begin
            w_countNext = r_count - 16'd1;
            if (r_count == 16'd1) w_stateNext = RELEASE;
          end
        end
`ifdef PROBE_ARB_TIMEOUT_EN
        // A stalled packet is abandoned without the release ACK so the uplink is not held forever.
        if (w_xfer) begin
          w_stallNext = '0;
        end else if (r_stall == StallLimit) begin
          ERR             = 1'b1;
          w_stallNext     = '0;
          w_stateNext     = IDLE;
          w_lastGrantNext = r_owner;
        end else begin
          w_stallNext = r_stall + 16'd1;
        end
`endif
      end
      RELEASE: begin
        w_ackPad[r_owner] = 1'b1;
        w_lastGrantNext   = r_owner;
        w_stateNext       = IDLE;
      end
      default: w_stateNext = IDLE;
    endcase
  end

  always_ff @(posedge UCLK or negedge URST) begin
    if (!URST) begin
      r_state     <= IDLE;
      r_owner     <= '0;
      r_lastGrant <= IdxWidth'(NumProbes - 1);
      r_count     <= '0;
`ifdef PROBE_ARB_TIMEOUT_EN
      r_stall     <= '0;
`endif
    end else begin
      r_state     <= w_stateNext;
      r_owner     <= w_ownerNext;
      r_lastGrant <= w_lastGrantNext;
      r_count     <= w_countNext;
`ifdef PROBE_ARB_TIMEOUT_EN
      r_stall     <= w_stallNext;
`endif
    end
  end

endmodule

// File: tb/tb_probe_uplink_arbiter.sv
// Self-checking bench for probe_uplink_arbiter: behavioural probe models plus a packet-level round-robin scoreboard.
module tb_probe_uplink_arbiter;

  localparam int NP    = 4;
  localparam int Depth = 128;

  logic          UCLK = 1'b0;
  logic          URST = 1'b1;
  logic [NP-1:0] REQVALID = '0;
  logic [32*NP-1:0] REQDATA = '0;
  logic [NP-1:0] REQACK;
  logic          OUTVALID;
  logic [31:0]   OUTDATA;
  logic          OUTACK = 1'b0;
  logic          BUSY;
  logic [1:0]    OWNER;
  logic          ERR;

  probe_uplink_arbiter #(.NumProbes(NP), .IdxWidth(2), .TimeoutCycles(8)) dut (
    .UCLK(UCLK), .URST(URST), .REQVALID(REQVALID), .REQDATA(REQDATA), .REQACK(REQACK),
    .OUTVALID(OUTVALID), .OUTDATA(OUTDATA), .OUTACK(OUTACK), .BUSY(BUSY), .OWNER(OWNER), .ERR(ERR)
  );

  always #5 UCLK = ~UCLK;

  int checks = 0;
  int fails  = 0;

  // Probe model: flattened words of queued packets, remaining data words, and release-wait flag.
  logic [31:0] pMem [NP][Depth];
  int          pHead [NP];
  int          pTail [NP];
  int          pRem  [NP];
  bit          pRel  [NP];
  bit          pHold [NP];
  logic [31:0] pLast [NP];
  int          ackCnt [NP];
  bit          gapEn;

  logic        obsValid, obsBusy, obsErr, obsOutAck;
  logic [31:0] obsData;
  logic [NP-1:0] obsAck;
  logic [1:0]  obsOwner;

  task automatic driveProbes();
    bit gap, v;
    for (int i = 0; i < NP; i++) begin
      gap = (pRem[i] > 0) && (pHold[i] || (gapEn && ($urandom_range(0, 7) == 0)));
      v   = !gap && (pRel[i] || (pHead[i] < pTail[i]));
      REQVALID[i] = v;
      if (!v)           REQDATA[32*i +: 32] = $urandom();
      else if (pRel[i]) REQDATA[32*i +: 32] = pLast[i];
      else              REQDATA[32*i +: 32] = pMem[i][pHead[i]];
    end
  endtask

  task automatic clearProbes();
    for (int i = 0; i < NP; i++) begin
      pHead[i] = 0; pTail[i] = 0; pRem[i] = 0; pRel[i] = 0;
      pHold[i] = 0; pLast[i] = '0; ackCnt[i] = 0;
    end
    gapEn = 0;
    driveProbes();
  endtask

  task automatic loadWord(input int p, input logic [31:0] w);
    if (pTail[p] < Depth) begin
      pMem[p][pTail[p]] = w;
      pTail[p]++;
    end
  endtask

  task automatic advanceProbe(input int p);
    logic [31:0] w;
    if (pRel[p]) begin
      pRel[p] = 0;
    end else if (pHead[p] >= pTail[p]) begin
      checks++; fails++;
      $display("[TB] FAIL spurious_ack probe %0d: got REQACK=1, required 0 (nothing pending)", p);
    end else begin
      w = pMem[p][pHead[p]];
      pHead[p]++;
      pLast[p] = w;
      if (pRem[p] == 0) begin
        if (w[15:0] == 16'd0) pRel[p] = 1;
        else pRem[p] = int'(w[15:0]);
      end else begin
        pRem[p]--;
        if (pRem[p] == 0) pRel[p] = 1;
      end
    end
  endtask

  // One clock: sample outputs on the falling edge, then let probes react to the handshake after the rising edge.
  task automatic tick();
    @(negedge UCLK);
    obsValid = OUTVALID; obsData = OUTDATA; obsAck = REQACK; obsBusy = BUSY;
    obsOwner = OWNER; obsErr = ERR; obsOutAck = OUTACK;
    @(posedge UCLK);
    #1;
    for (int i = 0; i < NP; i++) begin
      if (obsAck[i]) begin
        ackCnt[i]++;
        advanceProbe(i);
      end
    end
    driveProbes();
  endtask

  task automatic resetDut();
    URST = 1'b0;
    OUTACK = 1'b0;
    clearProbes();
    repeat (2) @(posedge UCLK);
    #1 URST = 1'b1;
  endtask

  task automatic test_reset();
    #2 URST = 1'b0;
    clearProbes();
    loadWord(2, 32'h0002_0001);
    driveProbes();
    OUTACK = 1'b1;
    #1;
    checks++; if (OUTVALID !== 1'b0) begin fails++; $display("[TB] FAIL reset_outvalid: got %b required 0", OUTVALID); end
    checks++; if (OUTDATA !== 32'h0) begin fails++; $display("[TB] FAIL reset_outdata: got %h required 0", OUTDATA); end
    checks++; if (REQACK !== 4'b0) begin fails++; $display("[TB] FAIL reset_reqack: got %b required 0000", REQACK); end
    checks++; if (BUSY !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy: got %b required 0", BUSY); end
    checks++; if (ERR !== 1'b0) begin fails++; $display("[TB] FAIL reset_err: got %b required 0", ERR); end
    checks++; if (OWNER !== 2'd0) begin fails++; $display("[TB] FAIL reset_owner: got %0d required 0", OWNER); end
    repeat (2) @(posedge UCLK);
    #1 URST = 1'b1;
  endtask

  task automatic test_single_packet();
    logic [31:0] exp [4];
    exp[0] = 32'h0001_0003; exp[1] = 32'hA5A5_0001; exp[2] = 32'hB6B6_0002; exp[3] = 32'hC7C7_0003;
    resetDut();
    for (int k = 0; k < 4; k++) loadWord(1, exp[k]);
    OUTACK = 1'b1;
    driveProbes();
    tick();
    checks++; if (obsValid !== 1'b0) begin fails++; $display("[TB] FAIL single_idle_valid: got %b required 0", obsValid); end
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++; if (obsValid !== 1'b1 || obsData !== exp[k]) begin fails++; $display("[TB] FAIL single_word%0d: got valid=%b data=%h required valid=1 data=%h", k, obsValid, obsData, exp[k]); end
      checks++; if (obsAck !== 4'b0010 || obsOwner !== 2'd1) begin fails++; $display("[TB] FAIL single_ack%0d: got ack=%b owner=%0d required ack=0010 owner=1", k, obsAck, obsOwner); end
    end
    tick();
    checks++; if (obsAck !== 4'b0010 || obsValid !== 1'b0 || obsBusy !== 1'b1) begin fails++; $display("[TB] FAIL single_release: got ack=%b valid=%b busy=%b required ack=0010 valid=0 busy=1", obsAck, obsValid, obsBusy); end
    tick();
    checks++; if (obsBusy !== 1'b0) begin fails++; $display("[TB] FAIL single_idle_after: got busy=%b required 0", obsBusy); end
  endtask

  task automatic test_round_robin();
    int expOwners [5] = '{0, 1, 2, 3, 0};
    logic [31:0] expQ [$];
    int grants = 0;
    bit prevBusy = 0;
    logic [31:0] w;
    resetDut();
    for (int p = 0; p < NP; p++) begin
      loadWord(p, {16'(p), 16'd1});
      loadWord(p, 32'hD000_0000 | 32'(p));
    end
    loadWord(0, 32'h0000_0001);
    loadWord(0, 32'hD000_0010);
    for (int p = 0; p < NP; p++) begin
      expQ.push_back({16'(p), 16'd1});
      expQ.push_back(32'hD000_0000 | 32'(p));
    end
    expQ.push_back(32'h0000_0001);
    expQ.push_back(32'hD000_0010);
    OUTACK = 1'b1;
    driveProbes();
    for (int c = 0; c < 60; c++) begin
      tick();
      if (obsBusy && !prevBusy) begin
        if (grants < 5) begin
          checks++; if (obsOwner !== 2'(expOwners[grants])) begin fails++; $display("[TB] FAIL rr_owner%0d: got %0d required %0d", grants, obsOwner, expOwners[grants]); end
        end
        grants++;
      end
      if (obsValid && obsOutAck) begin
        w = (expQ.size() > 0) ? expQ.pop_front() : 32'hDEAD_BEEF;
        checks++; if (obsData !== w) begin fails++; $display("[TB] FAIL rr_stream: got %h required %h", obsData, w); end
      end
      prevBusy = obsBusy;
      if (expQ.size() == 0 && !obsBusy) break;
    end
    checks++; if (grants !== 5 || expQ.size() !== 0) begin fails++; $display("[TB] FAIL rr_grants: got %0d grants, %0d words left, required 5 grants, 0 left", grants, expQ.size()); end
  endtask

  task automatic test_zero_length();
    resetDut();
    loadWord(2, 32'h0002_0000);
    OUTACK = 1'b1;
    driveProbes();
    tick();
    tick();
    checks++; if (obsValid !== 1'b1 || obsData !== 32'h0002_0000 || obsAck !== 4'b0100) begin fails++; $display("[TB] FAIL zero_header: got valid=%b data=%h ack=%b required 1 00020000 0100", obsValid, obsData, obsAck); end
    tick();
    checks++; if (obsValid !== 1'b0 || obsAck !== 4'b0100) begin fails++; $display("[TB] FAIL zero_release: got valid=%b ack=%b required 0 0100", obsValid, obsAck); end
    tick();
    checks++; if (obsBusy !== 1'b0) begin fails++; $display("[TB] FAIL zero_idle: got busy=%b required 0", obsBusy); end
    repeat (3) tick();
    checks++; if (ackCnt[2] !== 2) begin fails++; $display("[TB] FAIL zero_ackcount: got %0d required 2", ackCnt[2]); end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp [3];
    int n = 0;
    bit seenBusy = 0;
    exp[0] = 32'h0003_0002; exp[1] = 32'h1111_2222; exp[2] = 32'h3333_4444;
    resetDut();
    for (int k = 0; k < 3; k++) loadWord(3, exp[k]);
    driveProbes();
    for (int c = 0; c < 30; c++) begin
      OUTACK = (c == 0) ? 1'b0 : (((c - 1) % 3) == 0);
      tick();
      if (obsValid && !obsOutAck) begin
        checks++; if (obsAck !== 4'b0) begin fails++; $display("[TB] FAIL bp_stall_ack: got %b required 0000", obsAck); end
      end
      if (obsValid && obsOutAck) begin
        checks++; if (n >= 3 || obsData !== exp[n % 3]) begin fails++; $display("[TB] FAIL bp_word%0d: got %h required %h", n, obsData, exp[n % 3]); end
        n++;
      end
      if (obsBusy) seenBusy = 1;
      else if (seenBusy) break;
    end
    checks++; if (n !== 3 || ackCnt[3] !== 4) begin fails++; $display("[TB] FAIL bp_totals: got words=%0d acks=%0d required 3 and 4", n, ackCnt[3]); end
  endtask

  task automatic test_async_reset();
    int c;
    resetDut();
    OUTACK = 1'b1;
    loadWord(0, 32'h0000_0001);
    loadWord(0, 32'h0BAD_0000);
    driveProbes();
    for (c = 0; c < 20 && ackCnt[0] < 3; c++) tick();
    loadWord(2, 32'h0002_0008);
    for (int k = 0; k < 8; k++) loadWord(2, 32'hE000_0000 | 32'(k));
    driveProbes();
    for (c = 0; c < 30 && pHead[2] < 4; c++) tick();
    checks++; if (OUTVALID !== 1'b1) begin fails++; $display("[TB] FAIL areset_pre_valid: got %b required 1", OUTVALID); end
    #2 URST = 1'b0;
    #1;
    checks++; if (OUTVALID !== 1'b0 || REQACK !== 4'b0 || BUSY !== 1'b0) begin fails++; $display("[TB] FAIL areset_instant: got valid=%b ack=%b busy=%b required 0 0000 0", OUTVALID, REQACK, BUSY); end
    @(posedge UCLK);
    #1 URST = 1'b1;
    clearProbes();
    loadWord(1, 32'h0001_0000);
    loadWord(0, 32'h0000_0000);
    driveProbes();
    for (c = 0; c < 10; c++) begin
      tick();
      if (obsBusy) break;
    end
    checks++; if (obsBusy !== 1'b1 || obsOwner !== 2'd0) begin fails++; $display("[TB] FAIL areset_first_grant: got busy=%b owner=%0d required 1 and 0", obsBusy, obsOwner); end
  endtask

  task automatic test_stall_timeout();
    resetDut();
    loadWord(1, 32'h0001_0004);
    for (int k = 0; k < 4; k++) loadWord(1, 32'h5000_0000 | 32'(k));
    loadWord(2, 32'h0002_0000);
    pHold[1] = 1;
    OUTACK = 1'b1;
    driveProbes();
    tick();
    tick();
    checks++; if (obsData !== 32'h0001_0004 || obsOwner !== 2'd1) begin fails++; $display("[TB] FAIL stall_header: got data=%h owner=%0d required 00010004 1", obsData, obsOwner); end
`ifdef PROBE_ARB_TIMEOUT_EN
    for (int s = 1; s <= 8; s++) begin
      tick();
      checks++; if (obsErr !== (s == 8)) begin fails++; $display("[TB] FAIL stall_err%0d: got %b required %b", s, obsErr, (s == 8)); end
    end
    tick();
    checks++; if (obsBusy !== 1'b0 || obsErr !== 1'b0) begin fails++; $display("[TB] FAIL stall_abort_idle: got busy=%b err=%b required 0 0", obsBusy, obsErr); end
    tick();
    checks++; if (obsBusy !== 1'b1 || obsOwner !== 2'd2) begin fails++; $display("[TB] FAIL stall_next_grant: got busy=%b owner=%0d required 1 2", obsBusy, obsOwner); end
`else
    for (int s = 1; s <= 20; s++) begin
      tick();
      checks++; if (obsErr !== 1'b0 || obsBusy !== 1'b1 || obsOwner !== 2'd1) begin fails++; $display("[TB] FAIL stall_hold%0d: got err=%b busy=%b owner=%0d required 0 1 1", s, obsErr, obsBusy, obsOwner); end
    end
`endif
  endtask

  task automatic test_random();
    logic [31:0] expQ [$];
    int expAck [NP];
    int mCur [NP];
    int lastG, p, len, nPk;
    bit done, found;
    logic [31:0] w;
    for (int iter = 0; iter < 3; iter++) begin
      resetDut();
      for (int i = 0; i < NP; i++) begin
        nPk = $urandom_range(0, 3);
        for (int k = 0; k < nPk; k++) begin
          len = $urandom_range(0, 5);
          loadWord(i, {16'($urandom()), 16'(len)});
          for (int d = 0; d < len; d++) loadWord(i, $urandom());
        end
        expAck[i] = 0;
        mCur[i] = 0;
      end
      // Whole packets leave in round-robin order over probes that still have packets queued.
      expQ.delete();
      lastG = NP - 1;
      forever begin
        found = 0;
        p = 0;
        for (int k = 1; k <= NP && !found; k++) begin
          p = (lastG + k) % NP;
          if (mCur[p] < pTail[p]) found = 1;
        end
        if (!found) break;
        len = int'(pMem[p][mCur[p]][15:0]);
        for (int d = 0; d <= len; d++) expQ.push_back(pMem[p][mCur[p] + d]);
        mCur[p] += len + 1;
        expAck[p] += len + 2;
        lastG = p;
      end
      gapEn = 1;
      driveProbes();
      done = 0;
      for (int c = 0; c < 3000 && !done; c++) begin
        OUTACK = ($urandom_range(0, 7) != 0);
        tick();
        if (obsValid && obsOutAck) begin
          w = (expQ.size() > 0) ? expQ.pop_front() : ~obsData;
          checks++; if (obsData !== w) begin fails++; $display("[TB] FAIL rand_word it%0d: got %h required %h", iter, obsData, w); end
        end
        if (!obsValid) begin
          checks++; if (obsData !== 32'h0) begin fails++; $display("[TB] FAIL rand_idle_data it%0d: got %h required 0", iter, obsData); end
        end
        checks++; if (obsErr !== 1'b0) begin fails++; $display("[TB] FAIL rand_err it%0d: got %b required 0", iter, obsErr); end
        done = !obsBusy;
        for (int i = 0; i < NP; i++) if (pHead[i] < pTail[i] || pRel[i]) done = 0;
      end
      checks++; if (!done || expQ.size() !== 0) begin fails++; $display("[TB] FAIL rand_drain it%0d: got done=%b left=%0d required 1 0", iter, done, expQ.size()); end
      for (int i = 0; i < NP; i++) begin
        checks++; if (ackCnt[i] !== expAck[i]) begin fails++; $display("[TB] FAIL rand_acks it%0d p%0d: got %0d required %0d", iter, i, ackCnt[i], expAck[i]); end
      end
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    $display("[TB] starting probe_uplink_arbiter bench");
    test_reset();
    test_single_packet();
    test_round_robin();
    test_zero_length();
    test_backpressure();
    test_async_reset();
    test_stall_timeout();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
